// File: rtl/ex_issue_stage.sv
// Execute-stage pipeline register: issues one request per selected multi-cycle unit per instruction,
// flags misaligned memory accesses (only when EX_ALE_CHECK_EN is defined) and registers payload plus exception info.
module ex_issue_stage #(
    parameter int PAYLOAD_W = 128,
    parameter int NUM_UNITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 flush,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [NUM_UNITS-1:0] in_unit_sel,
    output logic [NUM_UNITS-1:0] unit_req_valid,
    input  logic [NUM_UNITS-1:0] unit_req_ready,
    input  logic                 in_mem_en,
    input  logic [1:0]           in_mem_size,
    input  logic [31:0]          in_addr,
    input  logic                 in_exc,
    input  logic [5:0]           in_ecode,
    input  logic [8:0]           in_esubcode,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [NUM_UNITS-1:0] out_unit_sel,
    output logic                 out_exc,
    output logic [5:0]           out_ecode,
    output logic [8:0]           out_esubcode,
    output logic [31:0]          out_badv
);

    logic                 w_ale;
    logic                 w_exc_any;
    logic                 w_go;
    logic                 w_fire;
    logic [NUM_UNITS-1:0] w_req_vld;
    logic [NUM_UNITS-1:0] w_done;

    logic                 r_out_valid;
    logic [PAYLOAD_W-1:0] r_payload;
    logic [NUM_UNITS-1:0] r_unit_sel;
    logic                 r_exc;
    logic [5:0]           r_ecode;
    logic [8:0]           r_esubcode;
    logic [31:0]          r_badv;
    logic [NUM_UNITS-1:0] r_issued;

`ifdef EX_ALE_CHECK_EN
    always_comb begin
        w_ale = 1'b0;
        if (in_mem_en) begin
            if (in_mem_size == 2'd1)
                w_ale = in_addr[0];
            else if (in_mem_size[1])
                w_ale = |in_addr[1:0];
        end
    end
`else
    logic w_unused_mem;
    assign w_ale        = 1'b0;
    assign w_unused_mem = ^{in_mem_en, in_mem_size};
`endif

    assign w_exc_any = in_exc | w_ale;

    // A unit already served for this instruction is never asked again, even while the output stalls.
    assign w_req_vld = (in_valid && !w_exc_any && !flush && !rst) ? (in_unit_sel & ~r_issued)
                                                                   : '0;
    assign w_done    = ~in_unit_sel | r_issued | (w_req_vld & unit_req_ready);
    assign w_go      = !in_valid || flush || w_exc_any || (&w_done);
    assign in_ready  = !rst && (!in_valid || (w_go && out_ready));
    assign w_fire    = in_valid && w_go && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_payload   <= '0;
            r_unit_sel  <= '0;
            r_exc       <= 1'b0;
            r_ecode     <= '0;
            r_esubcode  <= '0;
            r_badv      <= '0;
            r_issued    <= '0;
        end else begin
            if (flush || w_fire)
                r_issued <= '0;
            else
                r_issued <= r_issued | (w_req_vld & unit_req_ready);

            if (flush)
                r_out_valid <= 1'b0;
            else if (out_ready)
                r_out_valid <= in_valid && w_go;

            if (w_fire) begin
                r_payload  <= in_payload;
                r_unit_sel <= in_unit_sel;
                r_badv     <= in_addr;
                r_exc      <= w_exc_any;
                // Upstream exception takes priority over a locally detected misalignment.
                if (in_exc) begin
                    r_ecode    <= in_ecode;
                    r_esubcode <= in_esubcode;
                end else if (w_ale) begin
                    r_ecode    <= 6'h09;
                    r_esubcode <= 9'h0;
                end else begin
                    r_ecode    <= 6'h0;
                    r_esubcode <= 9'h0;
                end
            end
        end
    end

    assign unit_req_valid = w_req_vld;
    assign out_valid      = r_out_valid;
    assign out_payload    = r_payload;
    assign out_unit_sel   = r_unit_sel;
    assign out_exc        = r_exc;
    assign out_ecode      = r_ecode;
    assign out_esubcode   = r_esubcode;
    assign out_badv       = r_badv;

endmodule
